divider32: RTL and testbench

DIVIDER32 -- requirements
Module: divider32

---
 rtl/divider32.sv | 162 ++++++++++++++++
 tb/tb_divider32.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : divider32                                                    |
// | Description : Multi-cycle restoring divider (one quotient bit per clock).  |
// |               Define DIV_SIGNED_EN for two's-complement operands.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module divider32 #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] Q,
    output logic [width-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             DZ,
    output logic             O
);

    localparam int               c_CW     = (width > 1) ? $clog2(width) : 1;
    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_CALC   = 2'd1;
    localparam logic [1:0]       c_DONE   = 2'd2;
    localparam logic [width-1:0] c_MINNEG = {1'b1, {(width-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [width-1:0] r_rem;
    logic [width-1:0] r_dvd;
    logic [width-1:0] r_dvs;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_ovf;
    logic [width-1:0] r_q;
    logic [width-1:0] r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic             r_o;

    logic             w_accept;
    logic             w_dz;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_ovf;
    logic [width-1:0] w_a_mag;
    logic [width-1:0] w_b_mag;
    logic [width:0]   w_shift;
    logic [width:0]   w_sub;
    logic             w_geq;
    logic [width-1:0] w_rem_nxt;
    logic [width-1:0] w_dvd_nxt;
    logic [width-1:0] w_q_fix;
    logic [width-1:0] w_r_fix;

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_dz     = (B == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = w_dz ? c_DONE : c_CALC;
            c_CALC:  if (r_cnt == '0) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operands are reduced to magnitudes up front so the core stays unsigned.
    always_comb begin
`ifdef DIV_SIGNED_EN
        w_a_neg = A[width-1];
        w_b_neg = B[width-1];
        w_a_mag = w_a_neg ? -A : A;
        w_b_mag = w_b_neg ? -B : B;
        w_ovf   = (A == c_MINNEG) && (B == '1);
`else
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        w_a_mag = A;
        w_b_mag = B;
        w_ovf   = 1'b0;
`endif
    end

    // Bit 'width' of the subtraction is the borrow: shift < 2*divisor always holds.
    always_comb begin
        w_shift   = {r_rem, r_dvd[width-1]};
        w_sub     = w_shift - {1'b0, r_dvs};
        w_geq     = ~w_sub[width];
        w_rem_nxt = w_geq ? w_sub[width-1:0] : w_shift[width-1:0];
        w_dvd_nxt = {r_dvd[width-2:0], w_geq};
        w_q_fix   = r_qneg ? -w_dvd_nxt : w_dvd_nxt;
        w_r_fix   = r_rneg ? -w_rem_nxt : w_rem_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_ovf  <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_o    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != c_IDLE);
            r_done <= (w_state_nxt == c_DONE);
            if (w_accept) begin
                r_rem  <= '0;
                r_dvd  <= w_a_mag;
                r_dvs  <= w_b_mag;
                r_cnt  <= c_CW'(width - 1);
                r_qneg <= w_a_neg ^ w_b_neg;
                r_rneg <= w_a_neg;
                r_ovf  <= w_ovf;
                if (w_dz) begin
                    r_q  <= '1;
                    r_r  <= A;
                    r_dz <= 1'b1;
                    r_o  <= 1'b0;
                end
            end else if (r_state == c_CALC) begin
                r_rem <= w_rem_nxt;
                r_dvd <= w_dvd_nxt;
                if (r_cnt == '0) begin
                    r_q  <= w_q_fix;
                    r_r  <= w_r_fix;
                    r_dz <= 1'b0;
                    r_o  <= r_ovf;
                end else begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign busy = r_busy;
    assign done = r_done;
    assign DZ   = r_dz;
    assign O    = r_o;

endmodule
`default_nettype wire

// File: tb/tb_divider32.sv
`default_nettype none
// Testbench for divider32: directed vector table, hand-written corner sequences
// and randomized operands against an arithmetic reference model.
module tb_divider32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dz;
    logic        o;

    int n_cmp = 0;
    int n_err = 0;

    divider32 #(.width(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Q     (q),
        .R     (r),
        .busy  (busy),
        .done  (done),
        .DZ    (dz),
        .O     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        logic        eo;
        int          elat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain language arithmetic plus the special-case rules.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] mq, output logic [31:0] mr,
                         output logic mdz, output logic mo);
        mdz = 1'b0;
        mo  = 1'b0;
        if (mb == 32'd0) begin
            mq  = 32'hFFFF_FFFF;
            mr  = ma;
            mdz = 1'b1;
        end
`ifdef DIV_SIGNED_EN
        else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
            mq = 32'h8000_0000;
            mr = 32'd0;
            mo = 1'b1;
        end else begin
            mq = $signed(ma) / $signed(mb);
            mr = $signed(ma) % $signed(mb);
        end
`else
        else begin
            mq = ma / mb;
            mr = ma % mb;
        end
`endif
    endtask

    // Called just after a falling edge with the DUT idle; returns one cycle after done.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_in,
                           output logic [31:0] oq, output logic [31:0] orr,
                           output logic odz, output logic oo, output int olat);
        a     = ta;
        b     = tb_in;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        olat  = 1;
        while (!done && olat < 100) begin
            @(negedge clk);
            olat++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles for 0x%08h/0x%08h", olat, ta, tb_in);
        end
        oq  = q;
        orr = r;
        odz = dz;
        oo  = o;
        check("busy_at_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_single_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] gq, gr, mq, mr;
    logic        gdz, go, mdz, mo;
    int          lat, ndone, first;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        check("rst_o", {31'd0, o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 1'b1, 33});
        vecs.push_back('{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0, 33});
        vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        vecs.push_back('{32'h8000_0000, 32'd1,        32'h8000_0000, 32'd0,        1'b0, 1'b0, 33});
        vecs.push_back('{32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0, 1});
        vecs.push_back('{32'd100,       32'd7,        32'd14,        32'd2,        1'b0, 1'b0, 33});
        vecs.push_back('{32'd1234,      32'd0,        32'hFFFF_FFFF, 32'd1234,     1'b1, 1'b0, 1});
`else
        vecs.push_back('{32'd100,       32'd7,        32'd14,        32'd2,        1'b0, 1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0, 33});
        vecs.push_back('{32'd5,         32'd9,        32'd0,         32'd5,        1'b0, 1'b0, 33});
        vecs.push_back('{32'd1234,      32'd0,        32'hFFFF_FFFF, 32'd1234,     1'b1, 1'b0, 1});
        vecs.push_back('{32'd50,        32'd5,        32'd10,        32'd0,        1'b0, 1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 1'b0, 33});
        vecs.push_back('{32'h8000_0000, 32'd3,        32'd715827882, 32'd2,        1'b0, 1'b0, 33});
        vecs.push_back('{32'd0,         32'd3,        32'd0,         32'd0,        1'b0, 1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFF, 32'd10,       32'd429496729, 32'd5,        1'b0, 1'b0, 33});
`endif

        // Back-to-back: each run_div starts in the idle cycle right after the previous done.
        foreach (vecs[i]) begin
            run_div(vecs[i].va, vecs[i].vb, gq, gr, gdz, go, lat);
            check($sformatf("vec%0d_q", i), gq, vecs[i].eq);
            check($sformatf("vec%0d_r", i), gr, vecs[i].er);
            check($sformatf("vec%0d_dz", i), {31'd0, gdz}, {31'd0, vecs[i].edz});
            check($sformatf("vec%0d_o", i), {31'd0, go}, {31'd0, vecs[i].eo});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
        end

        // Start re-asserted mid-calculation must be ignored.
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 45; k++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            if (k == 10) begin
                check("busy_in_calc", {31'd0, busy}, 32'd1);
                a = 32'd9; b = 32'd3; start = 1'b1;
            end
            if (k == 11) start = 1'b0;
            @(negedge clk);
        end
        check("ignored_start_done_count", ndone, 32'd1);
        check("ignored_start_done_cycle", first, 32'd33);
        check("ignored_start_q_held", q, 32'd14);
        check("ignored_start_r_held", r, 32'd2);

        // Asynchronous reset in the middle of CALC.
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_q", q, 32'd0);
        check("midrst_r", r, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_dz", {31'd0, dz}, 32'd0);
        check("midrst_o", {31'd0, o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("midrst_no_activity", ndone, 32'd0);
        run_div(32'd50, 32'd5, gq, gr, gdz, go, lat);
        check("after_rst_q", gq, 32'd10);
        check("after_rst_r", gr, 32'd0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ra, rb;
            int sel;
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel <= 2) rb = $urandom_range(1, 15);
            else if (sel == 3) rb = rb >> $urandom_range(0, 31);
            else if (sel == 4) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            model(ra, rb, mq, mr, mdz, mo);
            run_div(ra, rb, gq, gr, gdz, go, lat);
            check($sformatf("rnd%0d_q(0x%08h/0x%08h)", n, ra, rb), gq, mq);
            check($sformatf("rnd%0d_r", n), gr, mr);
            check($sformatf("rnd%0d_dz", n), {31'd0, gdz}, {31'd0, mdz});
            check($sformatf("rnd%0d_o", n), {31'd0, go}, {31'd0, mo});
            check($sformatf("rnd%0d_latency", n), lat, mdz ? 32'd1 : 32'd33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
